// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, FSM state type and baud helper
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    // Rounded divide so the bit period error stays within half a clock
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - synchronous FIFO with level output, no fall-through
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_level == (AW+1)'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_rdata = r_mem[r_rd_ptr];

    // A full FIFO refuses the push even when a pop frees a slot this cycle
    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo_cfg.sv
// rtl/uart_tx_fifo_cfg.sv - configurable UART transmitter with input FIFO
module uart_tx_fifo_cfg
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 1000000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [DATA_BITS-1:0]          in_data,
    output logic                          in_ready,
    output logic                          tx,
    output logic                          tx_busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
    localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;

    if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < PARITY_NONE || PARITY > PARITY_EVEN ||
        STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || CPB < 2) begin : g_bad_params
        $fatal(1, "uart_tx_fifo_cfg: illegal parameter combination");
    end

    tx_state_e            r_state;
    tx_state_e            w_next;
    logic [CW-1:0]        r_baud;
    logic [3:0]           r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;
    logic                 r_tx;
    logic                 r_done;

    logic                 w_tick;
    logic                 w_data_last;
    logic                 w_stop_last;
    logic                 w_frame_end;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic [DATA_BITS-1:0] w_head;
    logic                 w_head_par;
    logic                 w_tx_next;

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (in_valid),
        .i_pop   (w_pop),
        .i_wdata (in_data),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (fifo_level)
    );

    assign w_tick      = (r_baud == CW'(CPB - 1));
    assign w_data_last = (r_bit == 4'(DATA_BITS - 1));
    assign w_stop_last = (r_bit == 4'(STOP_BITS - 1));
    assign w_frame_end = (r_state == ST_STOP) && w_tick && w_stop_last;
    assign w_pop       = !w_empty && ((r_state == ST_IDLE) || w_frame_end);
    assign w_head_par  = (PARITY == PARITY_ODD) ? ~^w_head : ^w_head;

    assign in_ready = !w_full;
    assign tx       = r_tx;
    assign tx_done  = r_done;
    assign tx_busy  = (r_state != ST_IDLE) || (fifo_level != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (!w_empty) w_next = ST_START;
            ST_START:  if (w_tick) w_next = ST_DATA;
            ST_DATA:   if (w_tick && w_data_last)
                           w_next = (PARITY == PARITY_NONE) ? ST_STOP : ST_PARITY;
            ST_PARITY: if (w_tick) w_next = ST_STOP;
            ST_STOP:   if (w_frame_end) w_next = w_empty ? ST_IDLE : ST_START;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_tx_next = 1'b1;
        case (r_state)
            ST_START:  w_tx_next = 1'b0;
            ST_DATA:   w_tx_next = r_shift[0];
            ST_PARITY: w_tx_next = r_par;
            default:   w_tx_next = 1'b1;
        endcase
    end

    // tx and tx_done trail the state by one clock so both come straight from flops
    always_ff @(posedge clk) begin
        if (rst) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_tx    <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_tx   <= w_tx_next;
            r_done <= w_frame_end;
            if (w_pop) begin
                r_baud  <= '0;
                r_bit   <= '0;
                r_shift <= w_head;
                r_par   <= w_head_par;
            end else if (r_state == ST_IDLE) begin
                r_baud <= '0;
                r_bit  <= '0;
            end else if (w_tick) begin
                r_baud <= '0;
                r_bit  <= (w_next != r_state) ? 4'd0 : r_bit + 1'b1;
                if (r_state == ST_DATA) begin
                    r_shift <= r_shift >> 1;
                end
            end else begin
                r_baud <= r_baud + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_cfg.sv
// tb/tb_uart_tx_fifo_cfg.sv - scoreboard bench over four UART TX configurations
module tb_uart_tx_fifo_cfg;

    // instance g: DATA_BITS / PARITY / STOP_BITS (index 0 is the LSB slot)
    localparam logic [3:0][3:0] DB = {4'd7, 4'd8, 4'd8, 4'd8};
    localparam logic [3:0][1:0] PA = {2'd0, 2'd1, 2'd2, 2'd0};
    localparam logic [3:0][1:0] SB = {2'd2, 2'd1, 2'd1, 2'd1};
    localparam int CPB = 10;

    typedef struct {
        logic [11:0] bits;
        int          len;
        bit          contig;
    } frame_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      vld;
    logic [3:0][8:0] din;
    logic [3:0]      rdy;
    logic [3:0]      txl;
    logic [3:0]      busy;
    logic [3:0]      donel;
    logic [3:0][2:0] lvl;

    int     n_checks = 0;
    int     n_pass   = 0;
    int     sel      = 0;
    int     cycle_n  = 0;
    int     last_end = -100;
    int     stray    = 0;
    bit     in_frame = 0;
    bit     abort    = 0;
    bit     saw_full = 0;
    frame_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cycle_n++;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int W = int'(DB[g]);
        uart_tx_fifo_cfg #(
            .CLK_FREQ   (1000000),
            .BAUD       (100000),
            .DATA_BITS  (W),
            .PARITY     (int'(PA[g])),
            .STOP_BITS  (int'(SB[g])),
            .FIFO_DEPTH (4)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .in_valid   (vld[g]),
            .in_data    (din[g][W-1:0]),
            .in_ready   (rdy[g]),
            .tx         (txl[g]),
            .tx_busy    (busy[g]),
            .tx_done    (donel[g]),
            .fifo_level (lvl[g])
        );
    end

    task automatic check_eq(input string tag, input int act, input int expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, act, expv);
    endtask

    function automatic frame_t make_frame(input logic [8:0] d, input int db, input int pa,
                                          input int sb, input bit contig);
        frame_t f;
        int n = 1;
        int ones = 0;
        f.bits = '0;
        for (int i = 0; i < db; i++) begin
            f.bits[n] = d[i];
            ones += int'(d[i]);
            n++;
        end
        if (pa != 0) begin
            f.bits[n] = (pa == 2) ? 1'(ones % 2) : 1'(1 - ones % 2);
            n++;
        end
        for (int i = 0; i < sb; i++) begin
            f.bits[n] = 1'b1;
            n++;
        end
        f.len    = n;
        f.contig = contig;
        return f;
    endfunction

    // Frame monitor: checks every cycle of each frame against the expected bit pattern
    initial begin : monitor
        frame_t      e;
        int          nbad, ndone, done_at;
        logic [11:0] got;
        bit          aborted;
        forever begin
            @(negedge clk);
            if (donel[sel]) stray++;
            if (!rst && txl[sel] === 1'b0) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_frame", 1, 0);
                    for (int w = 0; w < 200 && txl[sel] !== 1'b1; w++) @(negedge clk);
                end else begin
                    e = exp_q.pop_front();
                    in_frame = 1;
                    if (e.contig) check_eq("contig_gap", cycle_n - last_end - 1, 0);
                    nbad = 0; ndone = 0; done_at = -1; got = '0; aborted = 0;
                    for (int c = 0; c < e.len * CPB; c++) begin
                        if (c > 0) @(negedge clk);
                        if (abort) begin
                            aborted = 1;
                            abort = 0;
                            break;
                        end
                        if (txl[sel] !== e.bits[c / CPB]) nbad++;
                        if (c % CPB == CPB / 2) got[c / CPB] = txl[sel];
                        if (donel[sel]) begin
                            ndone++;
                            done_at = c;
                        end
                    end
                    in_frame = 0;
                    if (!aborted) begin
                        last_end = cycle_n;
                        check_eq("frame_bits", int'(got), int'(e.bits));
                        check_eq("bit_timing", nbad, 0);
                        check_eq("done_count", ndone, 1);
                        check_eq("done_cycle", done_at, e.len * CPB - 1);
                    end
                end
            end
        end
    end

    task automatic push_word(input int k, input logic [8:0] d, input bit contig);
        int guard = 0;
        bit noted = 0;
        @(negedge clk);
        vld[k] = 1'b1;
        din[k] = d;
        while (!rdy[k] && guard < 2000) begin
            if (!noted) begin
                check_eq("full_level", int'(lvl[k]), 4);
                saw_full = 1;
                noted = 1;
            end
            @(negedge clk);
            guard++;
        end
        if (guard >= 2000) check_eq("push_timeout", guard, 0);
        exp_q.push_back(make_frame(d, int'(DB[k]), int'(PA[k]), int'(SB[k]), contig));
        @(posedge clk);
    endtask

    task automatic release_inputs();
        @(negedge clk);
        vld = '0;
    endtask

    task automatic wait_quiet();
        int w = 0;
        while (!(exp_q.size() == 0 && !in_frame && !busy[sel]) && w < 3000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 3000) check_eq("quiet_timeout", w, 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int bad;
        int w;
        rst = 1'b1;
        vld = '0;
        din = '0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            check_eq("rst_tx", int'(txl[k]), 1);
            check_eq("rst_busy", int'(busy[k]), 0);
            check_eq("rst_done", int'(donel[k]), 0);
            check_eq("rst_ready", int'(rdy[k]), 1);
            check_eq("rst_level", int'(lvl[k]), 0);
        end
        rst = 1'b0;

        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (txl !== 4'hF || busy !== 4'h0 || donel !== 4'h0) bad++;
        end
        check_eq("idle_1000", bad, 0);

        // 8N1 0xA5 with first-frame latency
        sel = 0;
        push_word(0, 9'h0A5, 0);
        release_inputs();
        check_eq("lat_level", int'(lvl[0]), 1);
        check_eq("lat_edge1", int'(txl[0]), 1);
        @(negedge clk);
        check_eq("lat_edge2", int'(txl[0]), 1);
        check_eq("busy_start", int'(busy[0]), 1);
        @(negedge clk);
        check_eq("lat_fall", int'(txl[0]), 0);
        w = 0;
        while (!donel[0] && w < 300) begin
            @(negedge clk);
            w++;
        end
        check_eq("done_seen", int'(donel[0]), 1);
        @(negedge clk);
        check_eq("busy_after_done", int'(busy[0]), 0);
        wait_quiet();

        // 8E1 and 8O1 with 0x07
        sel = 1;
        push_word(1, 9'h007, 0);
        release_inputs();
        wait_quiet();
        sel = 2;
        push_word(2, 9'h007, 0);
        release_inputs();
        wait_quiet();

        // back-to-back stream of 8 words with in_valid held
        sel = 0;
        saw_full = 0;
        for (int i = 1; i <= 8; i++) push_word(0, 9'(i), i > 1);
        release_inputs();
        check_eq("ready_dropped", int'(saw_full), 1);
        wait_quiet();

        // reset during data bit 3 with two words queued
        push_word(0, 9'h05A, 0);
        push_word(0, 9'h033, 0);
        push_word(0, 9'h0C3, 0);
        release_inputs();
        repeat (44) @(negedge clk);
        rst = 1'b1;
        abort = 1;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        check_eq("midrst_tx", int'(txl[0]), 1);
        check_eq("midrst_level", int'(lvl[0]), 0);
        check_eq("midrst_busy", int'(busy[0]), 0);
        bad = 0;
        repeat (300) begin
            @(negedge clk);
            if (txl[0] !== 1'b1 || donel[0] !== 1'b0) bad++;
        end
        check_eq("midrst_quiet", bad, 0);
        push_word(0, 9'h096, 0);
        release_inputs();
        wait_quiet();

        // 7N2 0x41
        sel = 3;
        push_word(3, 9'h041, 0);
        release_inputs();
        wait_quiet();

        check_eq("stray_done", stray, 0);
        check_eq("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
